// File: rtl/seg7_pkg.sv
// Seven-segment glyph constants and pin polarity.
// Segment order is [0:6] = a..g, active-low.
package seg7_pkg;

    localparam logic [0:6] GLYPH_0 = 7'b0000001;
    localparam logic [0:6] GLYPH_1 = 7'b1001111;
    localparam logic [0:6] GLYPH_2 = 7'b0010010;
    localparam logic [0:6] GLYPH_3 = 7'b0000110;
    localparam logic [0:6] GLYPH_4 = 7'b1001100;
    localparam logic [0:6] GLYPH_5 = 7'b0100100;
    localparam logic [0:6] GLYPH_6 = 7'b0100000;
    localparam logic [0:6] GLYPH_7 = 7'b0001111;
    localparam logic [0:6] GLYPH_8 = 7'b0000000;
    localparam logic [0:6] GLYPH_9 = 7'b0001100;
    localparam logic [0:6] GLYPH_A = 7'b0001000;
    localparam logic [0:6] GLYPH_B = 7'b1100000;
    localparam logic [0:6] GLYPH_C = 7'b0110001;
    localparam logic [0:6] GLYPH_D = 7'b1000010;
    localparam logic [0:6] GLYPH_E = 7'b0110000;
    localparam logic [0:6] GLYPH_F = 7'b0111000;

    localparam logic [0:6] SEG_OFF = 7'b111_1111;

    localparam logic AN_ON  = 1'b0;
    localparam logic AN_OFF = 1'b1;
    localparam logic DP_ON  = 1'b0;
    localparam logic DP_OFF = 1'b1;

endpackage

// File: rtl/hex_scan_display_if.sv
// Datapath-side and pin-side signals of the hex scan display.
// master drives value/strobes, slave drives the display pins.
interface hex_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    lz_suppress;
    logic [0:6]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output value, load, dp_in, blank_mask, lz_suppress,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  value, load, dp_in, blank_mask, lz_suppress,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg7_decode.sv
// Nibble to active-low hex glyph lookup.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [0:6] seg
);
    always_comb begin
        seg = SEG_OFF;
        unique case (nib)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
        endcase
    end
endmodule

// File: rtl/hex_scan_display.sv
// Multiplexed seven-segment hex driver with frame-aligned updates,
// leading-zero suppression, blanking and decimal points.
module hex_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000
) (
    input logic clk,
    input logic reset,
    hex_scan_display_if.slave bus
);
    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          tick;
    logic          wrap;

    logic [VW-1:0]         pend_val, disp_val;
    logic [NUM_DIGITS-1:0] pend_dp, disp_dp;
    logic [NUM_DIGITS-1:0] pend_mask, disp_mask;
    logic                  pend_valid;

    logic [NUM_DIGITS-1:0] lead_zero;
    logic [3:0]            nib;
    logic [0:6]            glyph;
    logic                  dark;

    assign tick = (cnt == CW'(PRESCALE - 1));
    assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= wrap ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Display only changes at a wrap; a coincident load bypasses pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_mask  <= '0;
            pend_valid <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_mask  <= '0;
        end else if (wrap) begin
            pend_valid <= 1'b0;
            if (bus.load) begin
                disp_val  <= bus.value;
                disp_dp   <= bus.dp_in;
                disp_mask <= bus.blank_mask;
            end else if (pend_valid) begin
                disp_val  <= pend_val;
                disp_dp   <= pend_dp;
                disp_mask <= pend_mask;
            end
        end else if (bus.load) begin
            pend_val   <= bus.value;
            pend_dp    <= bus.dp_in;
            pend_mask  <= bus.blank_mask;
            pend_valid <= 1'b1;
        end
    end

    always_comb begin
        logic z;
        z = 1'b1;
        lead_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            z = z & (disp_val[4*k +: 4] == 4'h0);
            lead_zero[k] = z;
        end
    end

    assign nib  = disp_val[{idx, 2'b00} +: 4];
    assign dark = disp_mask[idx]
                | (bus.lz_suppress & (idx != '0) & lead_zero[idx]);

    seg7_decode u_dec (
        .nib (nib),
        .seg (glyph)
    );

    // Tick edge forces a dark guard cycle to avoid ghosting.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.an         <= {NUM_DIGITS{AN_OFF}};
            bus.seg        <= SEG_OFF;
            bus.dp         <= DP_OFF;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= wrap;
            if (tick || dark) begin
                bus.an  <= {NUM_DIGITS{AN_OFF}};
                bus.seg <= SEG_OFF;
                bus.dp  <= DP_OFF;
            end else begin
                bus.an  <= ~(NUM_DIGITS'(1) << idx);
                bus.seg <= glyph;
                bus.dp  <= disp_dp[idx] ? DP_ON : DP_OFF;
            end
        end
    end
endmodule

// File: tb/tb_hex_scan_display.sv
// Directed scoreboard bench for hex_scan_display (4 digits, prescale 4).
module tb_hex_scan_display;

    typedef struct {
        logic [3:0] an;
        logic [0:6] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    typedef struct {
        int          at;
        logic [15:0] v;
        logic [3:0]  dpv;
        logic [3:0]  mask;
    } ld_t;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;
    exp_t q[$];
    ld_t  sched[$];

    hex_scan_display_if #(.NUM_DIGITS(4)) bus ();

    hex_scan_display #(
        .NUM_DIGITS (4),
        .PRESCALE   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [0:6] gl(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0001100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    function automatic exp_t digit_exp(input int k, input logic [15:0] v,
                                       input logic [3:0] dpv,
                                       input logic [3:0] mask,
                                       input logic lz);
        exp_t e;
        logic [15:0] hi;
        hi = v >> (4 * k);
        e.fd = 1'b0;
        if (mask[k] || (lz && k != 0 && hi == 16'h0)) begin
            e.an  = 4'b1111;
            e.seg = 7'b1111111;
            e.dp  = 1'b1;
        end else begin
            e.an  = ~(4'b0001 << k);
            e.seg = gl(hi[3:0]);
            e.dp  = ~dpv[k];
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.frame_done !== 1'b1 && n < 40);
        chk("frame_done_seen", {31'b0, bus.frame_done}, 32'd1);
    endtask

    // Starts just after a wrap edge; checks the next full frame.
    task automatic check_frame(input logic [15:0] v, input logic [3:0] dpv,
                               input logic [3:0] mask, input logic lz);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 3) begin
                e.an  = 4'b1111;
                e.seg = 7'b1111111;
                e.dp  = 1'b1;
                e.fd  = (i == 15);
            end else begin
                e = digit_exp(i / 4, v, dpv, mask, lz);
            end
            q.push_back(e);
        end
        for (int i = 0; i < 16; i++) begin
            bus.load = 1'b0;
            if (sched.size() > 0 && sched[0].at == i) begin
                bus.load       = 1'b1;
                bus.value      = sched[0].v;
                bus.dp_in      = sched[0].dpv;
                bus.blank_mask = sched[0].mask;
                void'(sched.pop_front());
            end
            step();
            e = q.pop_front();
            chk($sformatf("an[%0d]", i), {28'b0, bus.an}, {28'b0, e.an});
            chk($sformatf("seg[%0d]", i), {25'b0, bus.seg}, {25'b0, e.seg});
            chk($sformatf("dp[%0d]", i), {31'b0, bus.dp}, {31'b0, e.dp});
            chk($sformatf("fd[%0d]", i), {31'b0, bus.frame_done},
                {31'b0, e.fd});
        end
        bus.load = 1'b0;
    endtask

    task automatic load_now(input logic [15:0] v, input logic [3:0] dpv,
                            input logic [3:0] mask);
        bus.load       = 1'b1;
        bus.value      = v;
        bus.dp_in      = dpv;
        bus.blank_mask = mask;
        step();
        bus.load = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.value       = '0;
        bus.load        = 1'b0;
        bus.dp_in       = '0;
        bus.blank_mask  = '0;
        bus.lz_suppress = 1'b0;

        // reset held three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_an", {28'b0, bus.an}, 32'hF);
            chk("rst_seg", {25'b0, bus.seg}, 32'h7F);
            chk("rst_dp", {31'b0, bus.dp}, 32'd1);
            chk("rst_fd", {31'b0, bus.frame_done}, 32'd0);
        end
        reset = 1'b0;
        step();
        chk("rel_an", {28'b0, bus.an}, 32'hE);
        chk("rel_seg", {25'b0, bus.seg}, {25'b0, gl(4'h0)});

        // basic scan, two consecutive frames
        load_now(16'h12AF, 4'b0000, 4'b0000);
        wait_frame();
        check_frame(16'h12AF, 4'b0000, 4'b0000, 1'b0);
        check_frame(16'h12AF, 4'b0000, 4'b0000, 1'b0);

        // leading-zero suppression
        bus.lz_suppress = 1'b1;
        load_now(16'h0030, 4'b0000, 4'b0000);
        wait_frame();
        check_frame(16'h0030, 4'b0000, 4'b0000, 1'b1);
        load_now(16'h0000, 4'b0000, 4'b0000);
        wait_frame();
        check_frame(16'h0000, 4'b0000, 4'b0000, 1'b1);

        // tear-free: two mid-frame loads, old value holds
        sched.push_back('{at: 2, v: 16'h1111, dpv: 4'b0, mask: 4'b0});
        sched.push_back('{at: 4, v: 16'h2222, dpv: 4'b0, mask: 4'b0});
        check_frame(16'h0000, 4'b0000, 4'b0000, 1'b1);

        // load coincident with the wrap tick bypasses pending
        sched.push_back('{at: 15, v: 16'h50C7, dpv: 4'b0001,
                          mask: 4'b0100});
        check_frame(16'h2222, 4'b0000, 4'b0000, 1'b1);
        sched.push_back('{at: 15, v: 16'h4321, dpv: 4'b0, mask: 4'b0});
        check_frame(16'h50C7, 4'b0001, 4'b0100, 1'b1);

        // reset while digit 2 is lit
        for (int i = 0; i < 9; i++) step();
        chk("mid_an", {28'b0, bus.an}, 32'hB);
        chk("mid_seg", {25'b0, bus.seg}, {25'b0, gl(4'h3)});
        reset = 1'b1;
        bus.lz_suppress = 1'b0;
        step();
        chk("mrst_an", {28'b0, bus.an}, 32'hF);
        chk("mrst_seg", {25'b0, bus.seg}, 32'h7F);
        chk("mrst_dp", {31'b0, bus.dp}, 32'd1);
        chk("mrst_fd", {31'b0, bus.frame_done}, 32'd0);
        reset = 1'b0;
        step();
        chk("mrel_an", {28'b0, bus.an}, 32'hE);
        chk("mrel_seg", {25'b0, bus.seg}, {25'b0, gl(4'h0)});
        wait_frame();
        check_frame(16'h0000, 4'b0000, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hex_scan_display.md
# hex_scan_display

Time-multiplexed driver for a bank of `NUM_DIGITS` common-anode seven-segment digits sharing one segment bus. It scans the digits in turn, decodes each 4-bit nibble to hex glyphs, and supports leading-zero suppression, per-digit blanking and decimal points. New values are applied only at frame boundaries, so the display never shows a mix of old and new digits. It sits between the datapath result registers and the board display pins, replacing one static decoder per digit.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned; range 2..8.
- `PRESCALE`, 50000: clock cycles per digit slot; minimum 2.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `value` input `4*NUM_DIGITS`: hex value; nibble k drives digit k, and digit 0 is the least significant.
- `load` input 1: single-cycle strobe that captures `value`, `dp_in` and `blank_mask`.
- `dp_in` input `NUM_DIGITS`: decimal point request per digit (1 = lit).
- `blank_mask` input `NUM_DIGITS`: 1 = force digit dark.
- `lz_suppress` input 1: level; 1 = blank leading zeros.
- `seg` output `[0:6]`: segments a..g, active-low; `seg[0]` = a.
- `dp` output 1: decimal point, active-low.
- `an` output `NUM_DIGITS`: digit enables, active-low, one-hot-low when active.
- `frame_done` output 1: one-cycle pulse at each frame wrap.

## Operation
- **Pending register.** On `load`, the captured fields go to a pending register and `pend_valid` is set. A second `load` before the wrap overwrites the pending register, so the last load wins.
- **Display register.** It feeds the decoder. It is updated from the pending register only on a wrap tick; `pend_valid` is cleared at the same time.
- **Load on a wrap tick.** If `load` coincides with a wrap tick, the live inputs bypass straight into the display register.
- **Scan counter.** `cnt` counts 0..`PRESCALE`-1. A tick is the cycle in which `cnt` equals `PRESCALE`-1. On a tick, `cnt` goes to 0 and `idx` goes to `idx`+1, wrapping from `NUM_DIGITS`-1 to 0. A wrap tick is a tick with `idx` = `NUM_DIGITS`-1.
- **Digit k is dark** if any of the following holds:
  - `blank_mask[k]` is set;
  - `lz_suppress`=1, nibble k is 0, every nibble above k is 0, and k≠0. Digit 0 is never suppressed.
- **Dark digit output:** `an` all inactive, `seg`=1111111, `dp`=1.
- **Glyphs (`seg[0:6]`):**
  - 0: 0000001, 1: 1001111, 2: 0010010, 3: 0000110
  - 4: 1001100, 5: 0100100, 6: 0100000, 7: 0001111
  - 8: 0000000, 9: 0001100, A: 0001000, b: 1100000
  - C: 0110001, d: 1000010, E: 0110000, F: 0111000
- **Decimal point:** `dp` = ~`dp_in[idx]` from the display register.

## Timing
- **Registered outputs.** `seg`, `dp`, `an` and `frame_done` are all registered.
- **Reset values.** While `reset`=1 at an edge:
  - outputs: `an` all 1, `seg`=1111111, `dp`=1, `frame_done`=0;
  - internal state: `cnt`=0, `idx`=0, display and pending registers 0, `pend_valid`=0.
- **Ghost guard.** At the edge ending a tick, `an` is driven all inactive for one cycle. At the following edge, `an`/`seg`/`dp` show the new `idx`. Each digit is therefore lit for `PRESCALE`-1 of its `PRESCALE` cycles.
- **After reset release.** At the first edge after `reset` is released, digit 0 is driven. There is no guard cycle here.
- **Frame period.** `NUM_DIGITS`×`PRESCALE` cycles.
- **`frame_done`.** High for exactly the cycle after the wrap-tick edge, which is the same cycle in which the new display register takes effect.
- **Input latency.** A load reaches the pins at most one frame plus 2 cycles later.
- **`lz_suppress`.** Sampled from the live input every cycle, with no latching.
- **Reset mid-scan.** Takes effect at the next edge and discards pending data.

## Structure
- **Shared package `seg7_pkg`:**
  - the 16 glyph constants;
  - `SEG_OFF` = 7'b111_1111;
  - the active-low polarity constants.
- **Sub-module `seg7_decode`:** combinational nibble → `[0:6]` lookup using the package constants. Instantiate one copy on the muxed nibble.
- **Top-level contents:** prescaler, index counter, pending/display registers, suppression logic and output registers.

## Test plan
Bench uses `NUM_DIGITS`=4, `PRESCALE`=4.
1. **Reset:** hold `reset` 3 cycles.
   - During reset: `an`=1111, `seg`=1111111, `dp`=1, `frame_done`=0.
   - First cycle after release: `an`=1110.
2. **Basic scan:** load 16'h12AF, `lz_suppress`=0.
   - After the wrap, the scan shows F(0111000) on `an`=1110, A(0001000) on 1101, 2(0010010) on 1011, 1(1001111) on 0111.
   - Each digit is lit 3 cycles with `an`=1111 for 1 cycle between digits.
   - `frame_done` pulses every 16 cycles.
3. **Leading-zero suppression:** load 16'h0030, `lz_suppress`=1.
   - Digits 3 and 2 are dark (`an`=1111 for their whole slot).
   - Digit 1 shows 3 (0000110); digit 0 shows 0 (0000001).
   - Load 16'h0000: only digit 0 lights, showing 0000001.
4. **Tear-free update:** load 16'h1111 mid-frame, then 16'h2222 two cycles later.
   - 1111 is never displayed.
   - 2222 appears in the cycle where `frame_done`=1.
   - The old value holds until then.
5. **Load on wrap tick / mask / dp:** `load` coincident with the wrap tick, with `dp_in`=0001 and `blank_mask`=0100.
   - The new value displays in the frame that starts immediately.
   - `dp`=0 only on digit 0.
   - Digit 2 is dark.
6. **Reset mid-scan:** assert `reset` while digit 2 is lit.
   - Next cycle shows the reset values.
   - After release, the scan restarts at digit 0 showing 0 (display register cleared).
